// File: rtl/sram_pkg.sv
// Shared definitions for the external 256Kx16 async SRAM controller and its traffic generator.
package sram_pkg;
  localparam int AW_DEF      = 18;
  localparam int DW_DEF      = 16;
  // 10 ns SRAM at 100 MHz: two cycles of access/strobe margin.
  localparam int RD_WAIT_DEF = 2;
  localparam int WR_WAIT_DEF = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_WSETUP = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_WHOLD  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    RD     = ST_RD,
    WSETUP = ST_WSETUP,
    WR     = ST_WR,
    WHOLD  = ST_WHOLD
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sram_ctrl.sv
// Single-beat valid/ready front end sequencing async SRAM pin cycles; all pins are registered.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d_o,
  output logic          sram_d_oe,
  input  logic [DW-1:0] sram_d_i,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_we
);
  localparam int CW = $clog2(max2(RD_WAIT, WR_WAIT) + 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [AW-1:0] a_d;
  logic [DW-1:0] do_d, rdata_d;
  logic          doe_d, cs_d, oe_d, we_d, rvld_d;

  assign req_ready = (state == IDLE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    a_d     = sram_a;
    do_d    = sram_d_o;
    doe_d   = sram_d_oe;
    cs_d    = sram_cs;
    oe_d    = sram_oe;
    we_d    = sram_we;
    rdata_d = rsp_rdata;
    rvld_d  = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        a_d  = req_addr;
        cs_d = 1'b0;
        if (req_we) begin
          // Data bus stays released for one cycle so a preceding read can turn around.
          state_d = WSETUP;
          do_d    = req_wdata;
          doe_d   = 1'b0;
          oe_d    = 1'b1;
          we_d    = 1'b1;
        end else begin
          state_d = RD;
          oe_d    = 1'b0;
          cnt_d   = CW'(RD_WAIT - 1);
        end
      end
      RD: if (cnt == '0) begin
        state_d = IDLE;
        rdata_d = sram_d_i;
        rvld_d  = 1'b1;
        cs_d    = 1'b1;
        oe_d    = 1'b1;
      end else cnt_d = cnt - CW'(1);
      WSETUP: begin
        state_d = WR;
        we_d    = 1'b0;
        doe_d   = 1'b1;
        cnt_d   = CW'(WR_WAIT - 1);
      end
      WR: if (cnt == '0) begin
        state_d = WHOLD;
        we_d    = 1'b1;
      end else cnt_d = cnt - CW'(1);
      WHOLD: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        doe_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sram_a    <= '0;
      sram_d_o  <= '0;
      sram_d_oe <= 1'b0;
      sram_cs   <= 1'b1;
      sram_oe   <= 1'b1;
      sram_we   <= 1'b1;
      rsp_rdata <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sram_a    <= a_d;
      sram_d_o  <= do_d;
      sram_d_oe <= doe_d;
      sram_cs   <= cs_d;
      sram_oe   <= oe_d;
      sram_we   <= we_d;
      rsp_rdata <= rdata_d;
      rsp_valid <= rvld_d;
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: default-timing controller plus a RD_WAIT=1/WR_WAIT=4 instance, each on an SRAM model.
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance 0: default timing
  logic        rv0 = 1'b0, rw0 = 1'b0, rdy0, vld0, doe0, cs0, oe0, we0;
  logic [17:0] ra0 = '0, a0;
  logic [15:0] wd0 = '0, rd0, do0, di0;
  logic [15:0] mem0 [0:255];

  // instance 1: RD_WAIT=1, WR_WAIT=4
  logic        rv1 = 1'b0, rw1 = 1'b0, rdy1, vld1, doe1, cs1, oe1, we1;
  logic [17:0] ra1 = '0, a1;
  logic [15:0] wd1 = '0, rd1, do1, di1;
  logic [15:0] mem1 [0:255];

  sram_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rdy0), .req_we(rw0),
    .req_addr(ra0), .req_wdata(wd0), .rsp_valid(vld0), .rsp_rdata(rd0),
    .sram_a(a0), .sram_d_o(do0), .sram_d_oe(doe0), .sram_d_i(di0),
    .sram_cs(cs0), .sram_oe(oe0), .sram_we(we0));

  sram_ctrl #(.RD_WAIT(1), .WR_WAIT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rdy1), .req_we(rw1),
    .req_addr(ra1), .req_wdata(wd1), .rsp_valid(vld1), .rsp_rdata(rd1),
    .sram_a(a1), .sram_d_o(do1), .sram_d_oe(doe1), .sram_d_i(di1),
    .sram_cs(cs1), .sram_oe(oe1), .sram_we(we1));

  // SRAM models: combinational read, word written on each edge seen with CS/WE low and bus driven
  assign di0 = mem0[a0[7:0]];
  assign di1 = mem1[a1[7:0]];
  always @(posedge clk) begin
    if (!cs0 && !we0 && doe0) mem0[a0[7:0]] <= do0;
    if (!cs1 && !we1 && doe1) mem1[a1[7:0]] <= do1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // bus-contention and strobe-ordering invariants, every cycle out of reset
  always @(negedge clk) if (rst_n) begin
    chk("inv_doe_vs_oe0", {30'd0, doe0, oe0}, {30'd0, doe0, doe0 ? 1'b1 : oe0});
    chk("inv_we_vs_doe0", {31'd0, !we0 && !doe0}, 32'd0);
    chk("inv_doe_vs_oe1", {31'd0, doe1 && !oe1}, 32'd0);
    chk("inv_we_vs_doe1", {31'd0, !we1 && !doe1}, 32'd0);
  end

  task automatic u1_write(input logic [17:0] a, input logic [15:0] d, output int wel);
    int n;
    wel = 0; n = 0;
    rv1 = 1'b1; rw1 = 1'b1; ra1 = a; wd1 = d;
    @(posedge clk); #1 rv1 = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      if (!we1) wel++;
      if (rdy1) break;
      n++;
    end
    if (n >= 20) chk("u1_write_timeout", 32'd1, 32'd0);
  endtask

  task automatic u1_read(input logic [17:0] a, output logic [15:0] d, output int lat);
    int n;
    n = 0; lat = -1; d = '0;
    rv1 = 1'b1; rw1 = 1'b0; ra1 = a;
    @(posedge clk); #1 rv1 = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      if (vld1) begin lat = n; d = rd1; break; end
      n++;
    end
    if (n >= 20) chk("u1_read_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int csl, wel, doel, oel, rdy_at, rsp_at, ws_at, pulses, lat;
    logic       doe_ws;
    logic [15:0] rdv, dat;
    logic [17:0] adr;
    for (int i = 0; i < 256; i++) begin mem0[i] = 16'h0; mem1[i] = 16'h0; end
    mem0[8'h42] = 16'h5A5A;

    // reset values
    #12;
    chk("rst_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_pins", {28'd0, cs0, oe0, we0, doe0}, 32'hE);
    chk("rst_rsp", {15'd0, vld0, rd0}, 32'd0);
    chk("rst_addr_do", {a0, do0}, 34'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // write 0x1A2B5 <- 0xBEEF
    rv0 = 1'b1; rw0 = 1'b1; ra0 = 18'h1A2B5; wd0 = 16'hBEEF;
    @(posedge clk); #1 rv0 = 1'b0;
    csl = 0; wel = 0; doel = 0; rdy_at = -1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) chk("wr_addr_do", {a0, do0}, {18'h1A2B5, 16'hBEEF});
      if (!cs0) csl++;
      if (!we0) wel++;
      if (doe0) doel++;
      if (rdy0 && rdy_at < 0) rdy_at = i;
    end
    chk("wr_cs_low", csl, 4);
    chk("wr_we_low", wel, 2);
    chk("wr_doe_high", doel, 3);
    chk("wr_ready_at", rdy_at, 4);
    chk("wr_mem", {16'd0, mem0[8'hB5]}, 32'hBEEF);

    // read 0x1A2B5
    rv0 = 1'b1; rw0 = 1'b0; ra0 = 18'h1A2B5;
    @(posedge clk); #1 rv0 = 1'b0;
    oel = 0; pulses = 0; rsp_at = -1; rdv = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!oe0) oel++;
      if (vld0) begin pulses++; rsp_at = i; rdv = rd0; end
    end
    chk("rd_pulses", pulses, 1);
    chk("rd_latency", rsp_at, 2);
    chk("rd_data", {16'd0, rdv}, 32'hBEEF);
    chk("rd_oe_low", oel, 2);
    chk("rd_data_held", {16'd0, rd0}, 32'hBEEF);

    // back-to-back read then write with valid held
    rv0 = 1'b1; rw0 = 1'b0; ra0 = 18'h00042;
    @(posedge clk); #1 rw0 = 1'b1; ra0 = 18'h00055; wd0 = 16'hC0DE;
    rsp_at = -1; ws_at = -1; doe_ws = 1'b1; rdv = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (vld0) begin rsp_at = i; rdv = rd0; end
      if (ws_at < 0 && !cs0 && oe0 && we0 && !doe0) begin
        ws_at = i; doe_ws = doe0; rv0 = 1'b0;
      end
    end
    chk("b2b_rsp_at", rsp_at, 2);
    chk("b2b_rd_data", {16'd0, rdv}, 32'h5A5A);
    chk("b2b_wsetup_at", ws_at, 3);
    chk("b2b_wsetup_doe", {31'd0, doe_ws}, 32'd0);
    chk("b2b_wr_mem", {16'd0, mem0[8'h55]}, 32'hC0DE);

    // RD_WAIT=1, WR_WAIT=4 instance: write/read pairs
    for (int i = 0; i < 256; i++) begin
      adr = {10'($urandom), 8'($urandom)};
      dat = 16'($urandom);
      u1_write(adr, dat, wel);
      chk("u1_we_width", wel, 4);
      u1_read(adr, rdv, lat);
      chk("u1_rd_data", {16'd0, rdv}, {16'd0, dat});
      if (i == 0) chk("u1_rd_latency", lat, 1);
    end

    // reset asserted during WR
    @(negedge clk);
    rv0 = 1'b1; rw0 = 1'b1; ra0 = 18'h00010; wd0 = 16'h1234;
    @(posedge clk); #1 rv0 = 1'b0;
    for (int i = 0; i < 6 && we0; i++) @(negedge clk);
    chk("abort_in_wr", {31'd0, we0}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pins", {28'd0, cs0, oe0, we0, doe0}, 32'hE);
    chk("abort_ready", {31'd0, rdy0}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (vld0) pulses++; end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin @(negedge clk); if (vld0) pulses++; end
    chk("abort_no_rsp", pulses, 0);

    // normal read after reset
    rv0 = 1'b1; rw0 = 1'b0; ra0 = 18'h00042;
    @(posedge clk); #1 rv0 = 1'b0;
    rsp_at = -1; rdv = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vld0) begin rsp_at = i; rdv = rd0; end
    end
    chk("post_rst_latency", rsp_at, 2);
    chk("post_rst_data", {16'd0, rdv}, 32'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
